// File: rtl/oldest2_issue_queue.sv
// ============================================================================
//  Module      : oldest2_issue_queue
//  Description : Age-ordered issue queue feeding a two-grant oldest-first
//                arbiter. Entries are allocated circularly, woken up by two
//                tag broadcast ports, and freed by the arbiter's grants.
//                The two issued payloads are registered. The head pointer
//                advances past freed entries one per cycle.
//  Config      : IQ_ALLOC_WAKEUP_EN - when defined, a wakeup broadcast in the
//                allocation cycle also readies the entry being allocated.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oldest2_issue_queue #(
    parameter int SEL_WIDTH      = 16,
    parameter int PRIORITY_WIDTH = 4,
    parameter int TAG_WIDTH      = 6,
    parameter int PAYLOAD_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        alloc_valid_i,
    output logic                        alloc_ready_o,
    input  logic [TAG_WIDTH-1:0]        alloc_src1_tag_i,
    input  logic                        alloc_src1_rdy_i,
    input  logic [TAG_WIDTH-1:0]        alloc_src2_tag_i,
    input  logic                        alloc_src2_rdy_i,
    input  logic [PAYLOAD_WIDTH-1:0]    alloc_payload_i,
    input  logic [1:0]                  wakeup_valid_i,
    input  logic [2*TAG_WIDTH-1:0]      wakeup_tag_i,
    output logic [SEL_WIDTH-1:0]        req_o,
    output logic [PRIORITY_WIDTH-1:0]   priority_fix_o,
    input  logic                        first_grant_valid_i,
    input  logic [PRIORITY_WIDTH-1:0]   first_grant_index_i,
    input  logic                        second_grant_valid_i,
    input  logic [PRIORITY_WIDTH-1:0]   second_grant_index_i,
    output logic                        issue0_valid_o,
    output logic [PAYLOAD_WIDTH-1:0]    issue0_payload_o,
    output logic                        issue1_valid_o,
    output logic [PAYLOAD_WIDTH-1:0]    issue1_payload_o
);

    localparam logic [PRIORITY_WIDTH:0] c_ptr_one = {{PRIORITY_WIDTH{1'b0}}, 1'b1};
    localparam logic [SEL_WIDTH-1:0]    c_bit_one = {{(SEL_WIDTH-1){1'b0}}, 1'b1};

    // Entry storage
    logic [SEL_WIDTH-1:0]     r_valid;
    logic [SEL_WIDTH-1:0]     r_src1_rdy;
    logic [SEL_WIDTH-1:0]     r_src2_rdy;
    logic [TAG_WIDTH-1:0]     r_src1_tag [SEL_WIDTH];
    logic [TAG_WIDTH-1:0]     r_src2_tag [SEL_WIDTH];
    logic [PAYLOAD_WIDTH-1:0] r_payload  [SEL_WIDTH];

    // Circular pointers, MSB is the wrap bit
    logic [PRIORITY_WIDTH:0]  r_head;
    logic [PRIORITY_WIDTH:0]  r_tail;

    logic [PRIORITY_WIDTH-1:0] w_head_idx;
    logic [PRIORITY_WIDTH-1:0] w_tail_idx;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_alloc_fire;
    logic [TAG_WIDTH-1:0]      w_wk_tag0;
    logic [TAG_WIDTH-1:0]      w_wk_tag1;
    logic [SEL_WIDTH-1:0]      w_wake1;
    logic [SEL_WIDTH-1:0]      w_wake2;
    logic                      w_alloc_wake1;
    logic                      w_alloc_wake2;
    logic                      w_grant0_ok;
    logic                      w_grant1_ok;
    logic [SEL_WIDTH-1:0]      w_free;

    assign w_head_idx   = r_head[PRIORITY_WIDTH-1:0];
    assign w_tail_idx   = r_tail[PRIORITY_WIDTH-1:0];
    assign w_empty      = (r_head == r_tail);
    assign w_full       = (w_head_idx == w_tail_idx) &&
                          (r_head[PRIORITY_WIDTH] != r_tail[PRIORITY_WIDTH]);
    assign w_alloc_fire = alloc_valid_i && !w_full;
    assign w_wk_tag0    = wakeup_tag_i[TAG_WIDTH-1:0];
    assign w_wk_tag1    = wakeup_tag_i[2*TAG_WIDTH-1:TAG_WIDTH];

    // A grant only takes effect on a live entry; a duplicate second grant is dropped
    assign w_grant0_ok  = first_grant_valid_i && r_valid[first_grant_index_i];
    assign w_grant1_ok  = second_grant_valid_i && r_valid[second_grant_index_i] &&
                          !(first_grant_valid_i && (second_grant_index_i == first_grant_index_i));

    assign alloc_ready_o  = !w_full;
    assign priority_fix_o = w_head_idx;
    assign req_o          = r_valid & r_src1_rdy & r_src2_rdy;

`ifdef IQ_ALLOC_WAKEUP_EN
    assign w_alloc_wake1 = (wakeup_valid_i[0] && (alloc_src1_tag_i == w_wk_tag0)) ||
                           (wakeup_valid_i[1] && (alloc_src1_tag_i == w_wk_tag1));
    assign w_alloc_wake2 = (wakeup_valid_i[0] && (alloc_src2_tag_i == w_wk_tag0)) ||
                           (wakeup_valid_i[1] && (alloc_src2_tag_i == w_wk_tag1));
`else
    assign w_alloc_wake1 = 1'b0;
    assign w_alloc_wake2 = 1'b0;
`endif

    // Per-entry tag match against both wakeup ports, and the grant free mask
    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        w_free  = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            w_wake1[i] = (wakeup_valid_i[0] && (r_src1_tag[i] == w_wk_tag0)) ||
                         (wakeup_valid_i[1] && (r_src1_tag[i] == w_wk_tag1));
            w_wake2[i] = (wakeup_valid_i[0] && (r_src2_tag[i] == w_wk_tag0)) ||
                         (wakeup_valid_i[1] && (r_src2_tag[i] == w_wk_tag1));
        end
        if (w_grant0_ok) w_free = w_free | (c_bit_one << first_grant_index_i);
        if (w_grant1_ok) w_free = w_free | (c_bit_one << second_grant_index_i);
    end

    // Entry state: allocation write, wakeup readiness and grant frees
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_src1_rdy <= '0;
            r_src2_rdy <= '0;
            for (int i = 0; i < SEL_WIDTH; i++) begin
                r_src1_tag[i] <= '0;
                r_src2_tag[i] <= '0;
                r_payload[i]  <= '0;
            end
        end else if (flush_i) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                // The tail slot is never live while not full, so it cannot be freed here
                if (w_alloc_fire && (w_tail_idx == PRIORITY_WIDTH'(i))) begin
                    r_valid[i]    <= 1'b1;
                    r_src1_tag[i] <= alloc_src1_tag_i;
                    r_src2_tag[i] <= alloc_src2_tag_i;
                    r_src1_rdy[i] <= alloc_src1_rdy_i || w_alloc_wake1;
                    r_src2_rdy[i] <= alloc_src2_rdy_i || w_alloc_wake2;
                    r_payload[i]  <= alloc_payload_i;
                end else begin
                    if (r_valid[i] && w_wake1[i]) r_src1_rdy[i] <= 1'b1;
                    if (r_valid[i] && w_wake2[i]) r_src2_rdy[i] <= 1'b1;
                    if (w_free[i])                r_valid[i]    <= 1'b0;
                end
            end
        end
    end

    // Head/tail pointers; head retires one freed entry per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_alloc_fire)
                r_tail <= r_tail + c_ptr_one;
            if (!w_empty && !r_valid[w_head_idx])
                r_head <= r_head + c_ptr_one;
        end
    end

    // Registered issue slots; payload holds when no grant is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue0_valid_o   <= 1'b0;
            issue0_payload_o <= '0;
            issue1_valid_o   <= 1'b0;
            issue1_payload_o <= '0;
        end else if (flush_i) begin
            issue0_valid_o <= 1'b0;
            issue1_valid_o <= 1'b0;
        end else begin
            issue0_valid_o <= w_grant0_ok;
            issue1_valid_o <= w_grant1_ok;
            if (w_grant0_ok) issue0_payload_o <= r_payload[first_grant_index_i];
            if (w_grant1_ok) issue1_payload_o <= r_payload[second_grant_index_i];
        end
    end

`ifndef SYNTHESIS
    // Flag grants that the queue drops (dead entry or duplicate index)
    always @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (first_grant_valid_i)
                assert (r_valid[first_grant_index_i])
                else $warning("iq: grant 0 to empty entry %0d dropped", first_grant_index_i);
            if (second_grant_valid_i)
                assert (r_valid[second_grant_index_i] &&
                        !(first_grant_valid_i && (second_grant_index_i == first_grant_index_i)))
                else $warning("iq: grant 1 to entry %0d dropped", second_grant_index_i);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_oldest2_issue_queue.sv
// ============================================================================
//  Module      : tb_oldest2_issue_queue
//  Description : Directed self-checking bench for oldest2_issue_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oldest2_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [5:0]  alloc_src1_tag_i;
    logic        alloc_src1_rdy_i;
    logic [5:0]  alloc_src2_tag_i;
    logic        alloc_src2_rdy_i;
    logic [31:0] alloc_payload_i;
    logic [1:0]  wakeup_valid_i;
    logic [11:0] wakeup_tag_i;
    logic [15:0] req_o;
    logic [3:0]  priority_fix_o;
    logic        first_grant_valid_i;
    logic [3:0]  first_grant_index_i;
    logic        second_grant_valid_i;
    logic [3:0]  second_grant_index_i;
    logic        issue0_valid_o;
    logic [31:0] issue0_payload_o;
    logic        issue1_valid_o;
    logic [31:0] issue1_payload_o;

    int tests = 0;
    int fails = 0;

    oldest2_issue_queue dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_i              (flush_i),
        .alloc_valid_i        (alloc_valid_i),
        .alloc_ready_o        (alloc_ready_o),
        .alloc_src1_tag_i     (alloc_src1_tag_i),
        .alloc_src1_rdy_i     (alloc_src1_rdy_i),
        .alloc_src2_tag_i     (alloc_src2_tag_i),
        .alloc_src2_rdy_i     (alloc_src2_rdy_i),
        .alloc_payload_i      (alloc_payload_i),
        .wakeup_valid_i       (wakeup_valid_i),
        .wakeup_tag_i         (wakeup_tag_i),
        .req_o                (req_o),
        .priority_fix_o       (priority_fix_o),
        .first_grant_valid_i  (first_grant_valid_i),
        .first_grant_index_i  (first_grant_index_i),
        .second_grant_valid_i (second_grant_valid_i),
        .second_grant_index_i (second_grant_index_i),
        .issue0_valid_o       (issue0_valid_o),
        .issue0_payload_o     (issue0_payload_o),
        .issue1_valid_o       (issue1_valid_o),
        .issue1_payload_o     (issue1_payload_o)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic [5:0] t1, input logic r1,
                             input logic [5:0] t2, input logic r2, input logic [31:0] p);
        alloc_valid_i    = 1'b1;
        alloc_src1_tag_i = t1;
        alloc_src1_rdy_i = r1;
        alloc_src2_tag_i = t2;
        alloc_src2_rdy_i = r2;
        alloc_payload_i  = p;
    endtask

    task automatic set_grants(input logic v0, input logic [3:0] i0,
                              input logic v1, input logic [3:0] i1);
        first_grant_valid_i  = v0;
        first_grant_index_i  = i0;
        second_grant_valid_i = v1;
        second_grant_index_i = i1;
    endtask

    logic [15:0] exp_aw;

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        alloc_valid_i = 1'b0;
        alloc_src1_tag_i = '0;
        alloc_src1_rdy_i = 1'b0;
        alloc_src2_tag_i = '0;
        alloc_src2_rdy_i = 1'b0;
        alloc_payload_i = '0;
        wakeup_valid_i = '0;
        wakeup_tag_i = '0;
        set_grants(1'b0, 4'd0, 1'b0, 4'd0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ready", alloc_ready_o, 1);
        check("rst_req", req_o, 16'h0000);
        check("rst_prio", priority_fix_o, 0);
        check("rst_i0v", issue0_valid_o, 0);
        check("rst_i1v", issue1_valid_o, 0);
        check("rst_i0p", issue0_payload_o, 0);

        // Fill all 16 entries; entry 3 has src1 tag 5 not yet ready
        for (int i = 0; i < 16; i++) begin
            if (i == 3) set_alloc(6'd5, 1'b0, 6'd0, 1'b1, 32'hA000_0000 + i);
            else        set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'hA000_0000 + i);
            step();
            if (i == 0)  check("first_alloc_req", req_o, 16'h0001);
            if (i == 14) check("ready_at_15", alloc_ready_o, 1);
        end
        alloc_valid_i = 1'b0;
        check("full_ready", alloc_ready_o, 0);
        check("full_req", req_o, 16'hFFF7);
        check("full_prio", priority_fix_o, 0);

        // Allocation attempt while full must be dropped
        set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'hDEAD_BEEF);
        step();
        alloc_valid_i = 1'b0;
        check("full_drop_ready", alloc_ready_o, 0);

        // Wakeup on port 1 with tag 5 readies entry 3
        wakeup_valid_i = 2'b10;
        wakeup_tag_i   = {6'd5, 6'd7};
        step();
        wakeup_valid_i = 2'b00;
        check("wakeup_req", req_o, 16'hFFFF);

        // Grants to entries 0 and 1
        set_grants(1'b1, 4'd0, 1'b1, 4'd1);
        step();
        set_grants(1'b0, 4'd0, 1'b0, 4'd0);
        check("g01_i0v", issue0_valid_o, 1);
        check("g01_i0p", issue0_payload_o, 32'hA000_0000);
        check("g01_i1v", issue1_valid_o, 1);
        check("g01_i1p", issue1_payload_o, 32'hA000_0001);
        check("g01_req", req_o, 16'hFFFC);
        check("g01_prio", priority_fix_o, 0);
        check("g01_ready", alloc_ready_o, 0);
        step();
        check("idle_i0v", issue0_valid_o, 0);
        check("idle_i1v", issue1_valid_o, 0);
        check("hold_i0p", issue0_payload_o, 32'hA000_0000);
        check("head1_prio", priority_fix_o, 1);
        check("head1_ready", alloc_ready_o, 1);
        step();
        check("head2_prio", priority_fix_o, 2);

        // Tail has wrapped: new allocations land in entries 0 then 1
        set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'hB000_0000);
        step();
        check("wrap_ready1", alloc_ready_o, 1);
        set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'hB000_0001);
        step();
        alloc_valid_i = 1'b0;
        check("wrap_full", alloc_ready_o, 0);
        check("wrap_req", req_o, 16'hFFFF);

        // Duplicate grant index 4: only slot 0 issues
        set_grants(1'b1, 4'd4, 1'b1, 4'd4);
        step();
        check("dup_i0v", issue0_valid_o, 1);
        check("dup_i0p", issue0_payload_o, 32'hA000_0004);
        check("dup_i1v", issue1_valid_o, 0);
        check("dup_i1p_hold", issue1_payload_o, 32'hA000_0001);
        check("dup_req", req_o, 16'hFFEF);

        // Grant to the now-empty entry 4 is dropped, entry 5 issues
        set_grants(1'b1, 4'd4, 1'b1, 4'd5);
        step();
        check("dead_i0v", issue0_valid_o, 0);
        check("dead_i1v", issue1_valid_o, 1);
        check("dead_i1p", issue1_payload_o, 32'hA000_0005);
        check("dead_req", req_o, 16'hFFCF);
        check("hole_prio", priority_fix_o, 2);

        // Free 2 and 3; head then walks 3,4,5,6 and stops at live entry 6
        set_grants(1'b1, 4'd2, 1'b1, 4'd3);
        step();
        set_grants(1'b0, 4'd0, 1'b0, 4'd0);
        check("g23_i0p", issue0_payload_o, 32'hA000_0002);
        check("g23_i1p", issue1_payload_o, 32'hA000_0003);
        check("g23_req", req_o, 16'hFFC3);
        for (int k = 3; k <= 7; k++) begin
            step();
            check("retire_prio", priority_fix_o, (k > 6) ? 6 : k);
        end

        // Entry 0 holds the wrapped allocation, not the dropped one
        set_grants(1'b1, 4'd0, 1'b0, 4'd0);
        step();
        set_grants(1'b0, 4'd0, 1'b0, 4'd0);
        check("wrap_i0p", issue0_payload_o, 32'hB000_0000);

        // Flush overrides allocation and grants
        flush_i = 1'b1;
        set_grants(1'b1, 4'd6, 1'b1, 4'd7);
        set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'hEEEE_0000);
        step();
        flush_i = 1'b0;
        alloc_valid_i = 1'b0;
        set_grants(1'b0, 4'd0, 1'b0, 4'd0);
        check("flush_req", req_o, 16'h0000);
        check("flush_i0v", issue0_valid_o, 0);
        check("flush_i1v", issue1_valid_o, 0);
        check("flush_prio", priority_fix_o, 0);
        check("flush_ready", alloc_ready_o, 1);

        // Tail restarts at entry 0
        set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'hC000_0000);
        step();
        check("post_flush_req", req_o, 16'h0001);

        // Allocate entry 1 waiting on tag 9 while tag 9 wakes up; also issue entry 0
        set_alloc(6'd9, 1'b0, 6'd0, 1'b1, 32'hD000_0001);
        wakeup_valid_i = 2'b01;
        wakeup_tag_i   = {6'd0, 6'd9};
        set_grants(1'b1, 4'd0, 1'b0, 4'd0);
        step();
        alloc_valid_i = 1'b0;
        set_grants(1'b0, 4'd0, 1'b0, 4'd0);
`ifdef IQ_ALLOC_WAKEUP_EN
        exp_aw = 16'h0002;
`else
        exp_aw = 16'h0000;
`endif
        check("alloc_wake_req", req_o, exp_aw);
        check("c0_i0p", issue0_payload_o, 32'hC000_0000);
        step();
        wakeup_valid_i = 2'b00;
        check("late_wake_req", req_o, 16'h0002);

        // Issue entry 1, then apply reset between edges
        set_grants(1'b1, 4'd1, 1'b0, 4'd0);
        step();
        set_grants(1'b0, 4'd0, 1'b0, 4'd0);
        check("d1_i0v", issue0_valid_o, 1);
        check("d1_i0p", issue0_payload_o, 32'hD000_0001);
        #2;
        rst = 1'b1;
        #1;
        check("arst_i0v", issue0_valid_o, 0);
        check("arst_i0p", issue0_payload_o, 0);
        check("arst_req", req_o, 16'h0000);
        check("arst_ready", alloc_ready_o, 1);
        check("arst_prio", priority_fix_o, 0);
        step();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
